// File: rtl/async_rr_arbiter.sv
// Round-robin arbiter sharing one req/ack upstream source among num_req requesters.
// Optional ARB_STATS_EN adds per-requester grant counters and a stray upstream-ack counter.
module async_rr_arbiter #(
  parameter int data_width = 32,
  parameter int num_req    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [num_req-1:0]      req,
  output logic [num_req-1:0]      ack,
  output logic [data_width-1:0]   dout,
  output logic                    req_up,
  input  logic                    ack_up,
  input  logic [data_width-1:0]   din_up,
  output logic [num_req-1:0]      grant,
  output logic                    busy
`ifdef ARB_STATS_EN
  ,
  output logic [num_req*32-1:0]   grant_count,
  output logic [31:0]             stray_ack
`endif
);

  localparam int PTR_W = $clog2(num_req);
  localparam logic [num_req-1:0] ONE = {{(num_req-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        win_q, win_d;
  logic [num_req-1:0]      ack_q, ack_d;
  logic [num_req-1:0]      grant_q, grant_d;
  logic                    req_up_q, req_up_d;
  logic                    busy_q, busy_d;
  logic [data_width-1:0]   dout_q, dout_d;

  logic [num_req-1:0]      elig;
  logic                    found;
  logic [PTR_W-1:0]        pick;
  logic [PTR_W-1:0]        ptr_next;

  // A requester whose ack is high this cycle must not be re-granted.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] cand;
    elig  = req & ~ack_q;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < num_req; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= num_req) idx = idx - num_req;
      cand = PTR_W'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign ptr_next = (win_q == PTR_W'(num_req - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    ack_d    = ack_q;
    grant_d  = grant_q;
    req_up_d = req_up_q;
    busy_d   = busy_q;
    dout_d   = dout_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d    = pick;
          grant_d  = ONE << pick;
          req_up_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (ack_up) begin
          dout_d   = din_up;
          ack_d    = ONE << win_q;
          req_up_d = 1'b0;
          ptr_d    = ptr_next;
          state_d  = DELIVER;
        end
      end
      DELIVER: begin
        ack_d   = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      ack_q    <= '0;
      grant_q  <= '0;
      req_up_q <= 1'b0;
      busy_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      req_up_q <= req_up_d;
      busy_q   <= busy_d;
      dout_q   <= dout_d;
    end
  end

  assign ack    = ack_q;
  assign dout   = dout_q;
  assign req_up = req_up_q;
  assign grant  = grant_q;
  assign busy   = busy_q;

`ifdef ARB_STATS_EN
  logic [31:0] grant_cnt_q [num_req];
  logic [31:0] stray_q;

  // Counters move on the same edge that sets ack, or that ignores a stray ack_up.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_req; i++) grant_cnt_q[i] <= '0;
      stray_q <= '0;
    end else if (ack_up) begin
      if (state_q == FETCH) grant_cnt_q[win_q] <= grant_cnt_q[win_q] + 32'd1;
      else                  stray_q <= stray_q + 32'd1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < num_req; i++) grant_count[i*32 +: 32] = grant_cnt_q[i];
  end

  assign stray_ack = stray_q;
`else
  // Statistics build disabled: handshake logic above is the whole design.
`endif

endmodule
